// File: rtl/bist_pkg.sv
// Shared BIST definitions: default widths, tap mask, seed, golden signature and command decode.
// Also used by the BIST controller.
package bist_pkg;

  localparam int          BIST_WIDTH   = 8;
  localparam logic [7:0]  BIST_POLY    = 8'hB8;
  localparam logic [7:0]  BIST_SEED    = 8'h01;
  localparam logic [7:0]  BIST_GOLDEN  = 8'h00;
  localparam int          BIST_COUNT_W = 16;

  typedef enum logic [1:0] {
    CMD_HOLD   = 2'd0,
    CMD_INIT   = 2'd1,
    CMD_FINISH = 2'd2,
    CMD_STEP   = 2'd3
  } bist_cmd_e;

  // Parity over the tapped bits; operands are zero-extended so any WIDTH up to 32 fits.
  function automatic logic tap_parity(input logic [31:0] state, input logic [31:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Next-state logic of a Fibonacci-style shift register: shift left, tap parity into bit 0,
// then XOR with an optional parallel input (tied to zero for a plain LFSR, response for a MISR).
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int               WIDTH = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = BIST_POLY
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] next_state
);

  assign next_state = {state[WIDTH-2:0], tap_parity(32'(state), 32'(POLY))} ^ data_in;

endmodule

// File: rtl/bist_signature_unit.sv
// BIST datapath: pattern LFSR driving the DUT, MISR compacting its response, cycle counter
// and a sticky golden-signature comparison triggered by the controller's finish strobe.
module bist_signature_unit
  import bist_pkg::*;
#(
  parameter int               WIDTH  = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY   = BIST_POLY,
  parameter logic [WIDTH-1:0] SEED   = BIST_SEED,
  parameter logic [WIDTH-1:0] GOLDEN = BIST_GOLDEN
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    init,
  input  logic                    mode,
  input  logic                    running,
  input  logic                    finish,
  input  logic [WIDTH-1:0]        dut_response,
  output logic [WIDTH-1:0]        pattern,
  output logic [WIDTH-1:0]        signature,
  output logic [BIST_COUNT_W-1:0] pattern_count,
  output logic                    result_valid,
  output logic                    pass,
  output logic                    fail
);

  localparam logic [BIST_COUNT_W-1:0] COUNT_MAX = {BIST_COUNT_W{1'b1}};

  logic [WIDTH-1:0]        pattern_r;
  logic [WIDTH-1:0]        signature_r;
  logic [BIST_COUNT_W-1:0] count_r;
  logic                    valid_r;
  logic                    pass_r;
  logic                    fail_r;

  logic [WIDTH-1:0]        pattern_step_s;
  logic [WIDTH-1:0]        pattern_next_s;
  logic [WIDTH-1:0]        misr_next_s;
  logic                    match_s;
  bist_cmd_e               cmd_s;

  bist_lfsr #(.WIDTH(WIDTH), .POLY(POLY)) u_pattern_gen (
    .state      (pattern_r),
    .data_in    ({WIDTH{1'b0}}),
    .next_state (pattern_step_s)
  );

  bist_lfsr #(.WIDTH(WIDTH), .POLY(POLY)) u_misr (
    .state      (signature_r),
    .data_in    (dut_response),
    .next_state (misr_next_s)
  );

  // An all-zero pattern would lock the generator up, so reseed instead.
  assign pattern_next_s = (pattern_step_s == {WIDTH{1'b0}}) ? SEED : pattern_step_s;
  assign match_s        = (signature_r == GOLDEN);

  // Command decode: init beats finish beats an active test cycle.
  always_comb begin
    cmd_s = CMD_HOLD;
    if (init) begin
      cmd_s = CMD_INIT;
    end else if (finish) begin
      cmd_s = CMD_FINISH;
    end else if (mode && running) begin
      cmd_s = CMD_STEP;
    end else begin
      cmd_s = CMD_HOLD;
    end
  end

  // State update; the finish cycle compares the held signature without compacting.
  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_r   <= SEED;
      signature_r <= {WIDTH{1'b0}};
      count_r     <= {BIST_COUNT_W{1'b0}};
      valid_r     <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      case (cmd_s)
        CMD_INIT: begin
          pattern_r   <= SEED;
          signature_r <= {WIDTH{1'b0}};
          count_r     <= {BIST_COUNT_W{1'b0}};
          valid_r     <= 1'b0;
          pass_r      <= 1'b0;
          fail_r      <= 1'b0;
        end
        CMD_FINISH: begin
          valid_r <= 1'b1;
          pass_r  <= match_s;
          fail_r  <= !match_s;
        end
        CMD_STEP: begin
          pattern_r   <= pattern_next_s;
          signature_r <= misr_next_s;
          if (count_r != COUNT_MAX) begin
            count_r <= count_r + {{(BIST_COUNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          pattern_r <= pattern_r;
        end
      endcase
    end
  end

  assign pattern       = pattern_r;
  assign signature     = signature_r;
  assign pattern_count = count_r;
  assign result_valid  = valid_r;
  assign pass          = pass_r;
  assign fail          = fail_r;

endmodule

// File: tb/tb_bist_signature_unit.sv
// Directed bench for bist_signature_unit with hand-computed LFSR/MISR values (POLY 8'hB8, SEED 8'h01),
// plus a 4-bit, zero-tap instance that walks the seed into the lockup guard.
module tb_bist_signature_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init = 1'b0;
  logic        mode = 1'b0;
  logic        running = 1'b0;
  logic        finish = 1'b0;
  logic [7:0]  dut_response = 8'h00;
  logic [7:0]  pattern;
  logic [7:0]  signature;
  logic [15:0] pattern_count;
  logic        result_valid;
  logic        pass;
  logic        fail;

  logic [3:0]  g_pattern;
  logic [3:0]  g_signature;
  logic [15:0] g_count;
  logic        g_valid;
  logic        g_pass;
  logic        g_fail;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  bist_signature_unit u_dut (
    .clock         (clock),
    .reset         (reset),
    .init          (init),
    .mode          (mode),
    .running       (running),
    .finish        (finish),
    .dut_response  (dut_response),
    .pattern       (pattern),
    .signature     (signature),
    .pattern_count (pattern_count),
    .result_valid  (result_valid),
    .pass          (pass),
    .fail          (fail)
  );

  bist_signature_unit #(.WIDTH(4), .POLY(4'h0), .SEED(4'h1), .GOLDEN(4'h0)) u_dut_guard (
    .clock         (clock),
    .reset         (reset),
    .init          (init),
    .mode          (mode),
    .running       (running),
    .finish        (finish),
    .dut_response  (4'h0),
    .pattern       (g_pattern),
    .signature     (g_signature),
    .pattern_count (g_count),
    .result_valid  (g_valid),
    .pass          (g_pass),
    .fail          (g_fail)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] pat, input logic [7:0] sig,
                             input logic [15:0] cnt);
    check({tag, ".pattern"}, pattern, pat);
    check({tag, ".signature"}, signature, sig);
    check({tag, ".count"}, pattern_count, cnt);
  endtask

  task automatic check_result(input string tag, input logic v, input logic p, input logic f);
    check({tag, ".valid"}, result_valid, v);
    check({tag, ".pass"}, pass, p);
    check({tag, ".fail"}, fail, f);
  endtask

  task automatic do_init();
    init = 1'b1;
    step();
    init = 1'b0;
  endtask

  logic [7:0] pat_seq [4] = '{8'h02, 8'h04, 8'h08, 8'h11};
  logic [3:0] guard_seq [4] = '{4'h2, 4'h4, 4'h8, 4'h1};

  initial begin
    // Reset state
    step();
    reset = 1'b0;
    check_state("reset", 8'h01, 8'h00, 16'd0);
    check_result("reset", 1'b0, 1'b0, 1'b0);
    check("reset.guard_pattern", g_pattern, 4'h1);

    // Pattern sequence; guard instance wraps 8 -> 0 -> reseed 1
    do_init();
    check("seq.init_pattern", pattern, 8'h01);
    mode = 1'b1; running = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("seq.pattern%0d", i), pattern, pat_seq[i]);
      check($sformatf("seq.guard%0d", i), g_pattern, guard_seq[i]);
    end
    check("seq.count", pattern_count, 16'd4);
    mode = 1'b0;

    // Seven zero-response cycles match golden 00
    do_init();
    mode = 1'b1; dut_response = 8'h00;
    for (int i = 0; i < 7; i++) step();
    mode = 1'b0;
    check("golden.signature", signature, 8'h00);
    check("golden.count", pattern_count, 16'd7);
    check("golden.pre_valid", result_valid, 1'b0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    check_result("golden", 1'b1, 1'b1, 1'b0);
    step();
    check_result("golden_hold", 1'b1, 1'b1, 1'b0);

    // Single-bit error 01 then zeros -> 11; finish with mode still high must not compact
    do_init();
    mode = 1'b1; dut_response = 8'h01;
    step();
    check("err.first", signature, 8'h01);
    dut_response = 8'h00;
    for (int i = 0; i < 4; i++) step();
    check_state("err", 8'h23, 8'h11, 16'd5);
    finish = 1'b1;
    step();
    finish = 1'b0;
    mode = 1'b0;
    check_state("err_fin", 8'h23, 8'h11, 16'd5);
    check_result("err", 1'b1, 1'b0, 1'b1);

    // Alternating mode: updates only on mode=1, mode without running holds
    do_init();
    mode = 1'b1; dut_response = 8'h00;
    step();
    check_state("alt1", 8'h02, 8'h00, 16'd1);
    mode = 1'b0; dut_response = 8'h5A;
    step();
    check_state("alt0", 8'h02, 8'h00, 16'd1);
    mode = 1'b1; dut_response = 8'h03;
    step();
    check_state("alt2", 8'h04, 8'h03, 16'd2);
    mode = 1'b0;
    step();
    check_state("alt3", 8'h04, 8'h03, 16'd2);
    mode = 1'b1; running = 1'b0;
    step();
    check_state("alt_norun", 8'h04, 8'h03, 16'd2);
    running = 1'b1; mode = 1'b0;

    // Reset mid-test discards progress and the result
    do_init();
    mode = 1'b1; dut_response = 8'h00;
    for (int i = 0; i < 3; i++) step();
    mode = 1'b0;
    finish = 1'b1;
    step();
    finish = 1'b0;
    check("rst.pre_valid", result_valid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_state("rst", 8'h01, 8'h00, 16'd0);
    check_result("rst", 1'b0, 1'b0, 1'b0);

    // init and finish together: init wins
    do_init();
    mode = 1'b1; dut_response = 8'h03;
    step();
    mode = 1'b0;
    check("both.pre_sig", signature, 8'h03);
    finish = 1'b1;
    step();
    check("both.pre_fail", fail, 1'b1);
    init = 1'b1;
    step();
    init = 1'b0; finish = 1'b0;
    check("both.signature", signature, 8'h00);
    check_result("both", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
